// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the load/store datapath controller: opcodes, FSM
// states, datapath select encodings and instruction field positions.
package datapath_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_LD   = 4'h0,
      OP_ST   = 4'h1,
      OP_ADD  = 4'h2,
      OP_LDI  = 4'h3,
      OP_SUB  = 4'h4,
      OP_JEQ  = 4'h5,
      OP_AND  = 4'h6,
      OP_OR   = 4'h7,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_ALU,
      S_LDI,
      S_JEQ,
      S_HALT
   } state_e;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   localparam logic [1:0] RFS_ALU   = 2'b00;
   localparam logic [1:0] RFS_MEM   = 2'b01;
   localparam logic [1:0] RFS_CONST = 2'b10;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RA_MSB = 11;
   localparam int RA_LSB = 8;
   localparam int RB_MSB = 7;
   localparam int RB_LSB = 4;
   localparam int RC_MSB = 3;
   localparam int RC_LSB = 0;
   localparam int D_MSB  = 7;
   localparam int D_LSB  = 0;

   function automatic logic isAluOp(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic [1:0] aluSelect(input logic [3:0] op);
      logic [1:0] sel;
      sel = ALU_ADD;
      case (op)
         OP_SUB:  sel = ALU_SUB;
         OP_AND:  sel = ALU_AND;
         OP_OR:   sel = ALU_OR;
         default: sel = ALU_ADD;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/datapath_controller.sv
// Multi-cycle FSM that fetches, decodes and executes 16-bit instructions by
// steering the register-file/ALU datapath and the instruction/data memories.
module datapath_controller
   import datapath_ctrl_pkg::*;
#(
   parameter int                     PC_WIDTH = 8,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic [PC_WIDTH-1:0] i_addr,
   output logic                i_rd,
   input  logic [15:0]         i_data,
   input  logic                i_ack,
   output logic [7:0]          d_addr,
   output logic                d_rd,
   output logic                d_wr,
   input  logic                d_ack,
   output logic [3:0]          Rf_writeAddress,
   output logic                Rf_we,
   output logic [3:0]          Rf_readAddress1,
   output logic [3:0]          Rf_readAddress2,
   output logic                alu_s1,
   output logic                alu_s0,
   output logic                Rf_s1,
   output logic                Rf_s0,
   output logic [7:0]          Rf_constData,
   input  logic                isEqual,
   output logic [PC_WIDTH-1:0] pc,
   output logic                halted
);

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;

   logic [3:0]          op, ra, rb, rc;
   logic [7:0]          dField;
   logic [PC_WIDTH-1:0] offExt;

   assign op     = ir_q[OP_MSB:OP_LSB];
   assign ra     = ir_q[RA_MSB:RA_LSB];
   assign rb     = ir_q[RB_MSB:RB_LSB];
   assign rc     = ir_q[RC_MSB:RC_LSB];
   assign dField = ir_q[D_MSB:D_LSB];
   assign offExt = {{(PC_WIDTH-4){rc[3]}}, rc};
   assign pc     = pc_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Outputs are forced low while reset is held so in-flight requests drop at once.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ir_d            = ir_q;
      i_addr          = '0;
      i_rd            = 1'b0;
      d_addr          = '0;
      d_rd            = 1'b0;
      d_wr            = 1'b0;
      Rf_writeAddress = '0;
      Rf_we           = 1'b0;
      Rf_readAddress1 = '0;
      Rf_readAddress2 = '0;
      {alu_s1, alu_s0} = ALU_ADD;
      {Rf_s1, Rf_s0}   = RFS_ALU;
      Rf_constData    = '0;
      halted          = 1'b0;

      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               i_rd   = 1'b1;
               i_addr = pc_q;
               if (i_ack) begin
                  ir_d    = i_data;
                  pc_d    = pc_q + PC_WIDTH'(1);
                  state_d = S_DECODE;
               end
            end
            // Unlisted opcodes are NOPs; they spend their execute cycle in
            // S_ALU with every datapath control left inactive.
            S_DECODE: begin
               case (op)
                  OP_LD:   state_d = S_LOAD;
                  OP_ST:   state_d = S_STORE;
                  OP_LDI:  state_d = S_LDI;
                  OP_JEQ:  state_d = S_JEQ;
                  OP_HALT: state_d = S_HALT;
                  default: state_d = S_ALU;
               endcase
            end
            S_LOAD: begin
               d_rd            = 1'b1;
               d_addr          = dField;
               {Rf_s1, Rf_s0}  = RFS_MEM;
               Rf_writeAddress = ra;
               Rf_we           = d_ack;
               if (d_ack) state_d = S_FETCH;
            end
            S_STORE: begin
               d_wr            = 1'b1;
               d_addr          = dField;
               Rf_readAddress1 = ra;
               if (d_ack) state_d = S_FETCH;
            end
            S_ALU: begin
               if (isAluOp(op)) begin
                  Rf_readAddress1  = rb;
                  Rf_readAddress2  = rc;
                  Rf_writeAddress  = ra;
                  Rf_we            = 1'b1;
                  {Rf_s1, Rf_s0}   = RFS_ALU;
                  {alu_s1, alu_s0} = aluSelect(op);
               end
               state_d = S_FETCH;
            end
            S_LDI: begin
               Rf_constData    = dField;
               {Rf_s1, Rf_s0}  = RFS_CONST;
               Rf_writeAddress = ra;
               Rf_we           = 1'b1;
               state_d         = S_FETCH;
            end
            // Branch offset is relative to the PC already advanced during fetch.
            S_JEQ: begin
               Rf_readAddress1 = ra;
               Rf_readAddress2 = rb;
               if (isEqual) pc_d = pc_q + offExt;
               state_d = S_FETCH;
            end
            S_HALT: begin
               halted = 1'b1;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule
